// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   Groups the ID-stage request and the interlock response of the issue-side
//   hazard scoreboard.
//   master : ID stage. It drives the decoded instruction and flush, and it
//            receives stall, pending_mask and (when built) stall_count.
//   slave  : the scoreboard itself.
//   stall_count exists only when HAZARD_STALL_CNT_EN is defined.
interface hazard_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic [1:0]  id_lat;
  logic        flush;
  logic        stall;
  logic [31:0] pending_mask;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_lat, flush,
    input  stall, pending_mask
`ifdef HAZARD_STALL_CNT_EN
    , input stall_count
`endif
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_lat, flush,
    output stall, pending_mask
`ifdef HAZARD_STALL_CNT_EN
    , output stall_count
`endif
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Issue-side interlock for the 5-stage pipeline. Every architectural
//   register r (1..31) holds a down-counter giving the number of cycles left
//   before its in-flight result can be bypassed. The ID stage is stalled while
//   a used source still has a nonzero count. A flush squashes the youngest
//   issued producer by clearing its counter.
// Ports
//   clk : pipeline clock, rising edge
//   rst : asynchronous, active-high reset
//   sb  : hazard_scoreboard_if.slave
//         inputs  id_valid, id_rs1/2, id_use_rs1/2, id_rd, id_regwrite, id_lat, flush
//         outputs stall, pending_mask, and stall_count (optional)
// Parameters
//   MAX_LAT : largest accepted producer latency. Larger id_lat values are
//             clamped to it.
// Build option
//   HAZARD_STALL_CNT_EN : adds a saturating 32-bit count of stalled cycles.

// One register's latency counter. Inside a lane the load takes priority over
// the flush clear, and the flush clear takes priority over the decrement.
module hazard_cnt_lane #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          clr,
  input  logic [CW-1:0] lat,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (ld)          cnt <= lat;
    else if (clr)         cnt <= '0;
    else if (cnt != '0)   cnt <= cnt - CW'(1);
  end
endmodule

module hazard_scoreboard #(
  parameter int MAX_LAT = 3
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave sb
);
  localparam int CW = $clog2(MAX_LAT + 1);

  logic [31:0][CW-1:0] cnt;
  logic [4:0]          last_rd;
  logic                last_vld;
  logic [CW-1:0]       lat_c;
  logic                hz1, hz2, issue, wr_en;

  // x0 never has an in-flight producer.
  assign cnt[0] = '0;

  // The sources are checked against the counters before this cycle's update.
  // A reader that also writes its own source therefore sees the old producer,
  // and never its own future entry.
  assign hz1   = sb.id_use_rs1 & (sb.id_rs1 != 5'd0) & (cnt[sb.id_rs1] != '0);
  assign hz2   = sb.id_use_rs2 & (sb.id_rs2 != 5'd0) & (cnt[sb.id_rs2] != '0);
  assign sb.stall = sb.id_valid & ~sb.flush & (hz1 | hz2);
  assign issue = sb.id_valid & ~sb.stall & ~sb.flush;
  assign wr_en = issue & sb.id_regwrite & (sb.id_rd != 5'd0);

  always_comb begin
    lat_c = CW'(sb.id_lat);
    if (int'(sb.id_lat) > MAX_LAT) lat_c = CW'(MAX_LAT);
  end

  // Per-register lanes. The flush clears only the entry issued last cycle.
  // Older entries keep counting down.
  for (genvar r = 1; r < 32; r++) begin : g_lane
    hazard_cnt_lane #(.CW(CW)) u_lane (
      .clk (clk),
      .rst (rst),
      .ld  (wr_en & (sb.id_rd == 5'(r))),
      .clr (sb.flush & last_vld & (last_rd == 5'(r))),
      .lat (lat_c),
      .cnt (cnt[r])
    );
  end

  always_comb begin
    sb.pending_mask = '0;
    for (int r = 1; r < 32; r++) sb.pending_mask[r] = (cnt[r] != '0);
  end

  // This tracks the youngest issued producer, which a flush in the next cycle
  // may cancel. A cycle without an issue leaves no flush target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_vld <= 1'b0;
      last_rd  <= '0;
    end else begin
      last_vld <= wr_en;
      if (wr_en) last_rd <= sb.id_rd;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  sb.stall_count <= '0;
    else if (sb.stall && (sb.stall_count != '1)) sb.stall_count <= sb.stall_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Directed vectors with hand-computed expectations for hazard_scoreboard.
//   Inputs change on the falling edge. Outputs are sampled 1 ns later, well
//   before the next rising edge.
module tb_hazard_scoreboard;
  logic clk, rst;
  int   nvec = 0;
  int   nmis = 0;

  hazard_scoreboard_if sb_if ();

  hazard_scoreboard #(.MAX_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic [1:0] lat, input logic fl);
    sb_if.id_valid    = v;
    sb_if.id_rs1      = rs1;
    sb_if.id_use_rs1  = u1;
    sb_if.id_rs2      = rs2;
    sb_if.id_use_rs2  = u2;
    sb_if.id_rd       = rd;
    sb_if.id_regwrite = rw;
    sb_if.id_lat      = lat;
    sb_if.flush       = fl;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // The bench samples stall, then the clock edge applies the update.
  task automatic cyc_stall(input string tag, input logic exp);
    #1;
    chk(tag, {31'b0, sb_if.stall}, {31'b0, exp});
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk("rst_stall", {31'b0, sb_if.stall}, 32'd0);
    chk("rst_pend", sb_if.pending_mask, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    chk("rst_scnt", sb_if.stall_count, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Multi-cycle stall, stall counter, and reset in the middle of a stall.
    drv(1, 0, 0, 0, 0, 9, 1, 2'd3, 0);  cyc_stall("mc_issue", 0);        // cnt9=3
    drv(1, 0, 0, 9, 1, 10, 1, 2'd1, 0);
    cyc_stall("mc_st1", 1);
    cyc_stall("mc_st2", 1);
    cyc_stall("mc_st3", 1);
    cyc_stall("mc_go", 0);                                               // cnt10=1
`ifdef HAZARD_STALL_CNT_EN
    chk("scnt3", sb_if.stall_count, 32'd3);
`endif
    drv(1, 10, 1, 0, 0, 11, 1, 2'd2, 0); cyc_stall("lu10_st", 1);
    cyc_stall("lu10_go", 0);                                             // cnt11=2
`ifdef HAZARD_STALL_CNT_EN
    chk("scnt4", sb_if.stall_count, 32'd4);
`endif
    drv(1, 11, 1, 0, 0, 0, 0, 2'd0, 0);
    #1;
    chk("pre_rst_stall", {31'b0, sb_if.stall}, 32'd1);
    chk("pre_rst_pend", sb_if.pending_mask, 32'h0000_0800);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", {31'b0, sb_if.stall}, 32'd0);
    chk("mid_rst_pend", sb_if.pending_mask, 32'd0);
`ifdef HAZARD_STALL_CNT_EN
    chk("mid_rst_scnt", sb_if.stall_count, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Load-use case: exactly one bubble.
    drv(1, 0, 0, 0, 0, 5, 1, 2'd1, 0);  cyc_stall("lu_issue", 0);        // cnt5=1
    drv(0, 5, 1, 0, 0, 6, 1, 2'd0, 0);
    #1;
    chk("lu_novalid", {31'b0, sb_if.stall}, 32'd0);
    drv(1, 5, 1, 0, 0, 6, 1, 2'd0, 0);
    #1;
    chk("lu_pend", sb_if.pending_mask, 32'h0000_0020);
    cyc_stall("lu_st", 1);
    chk("lu_pend_clr", sb_if.pending_mask, 32'd0);
    cyc_stall("lu_go", 0);

    // An ALU producer followed back-to-back by its reader, then writes to x0.
    drv(1, 0, 0, 0, 0, 7, 1, 2'd0, 0);  cyc_stall("alu_issue", 0);
    drv(1, 7, 1, 7, 1, 8, 0, 2'd0, 0);  cyc_stall("alu_rd", 0);
    drv(1, 0, 0, 0, 0, 0, 1, 2'd3, 0);  cyc_stall("x0_issue", 0);
    drv(1, 0, 1, 0, 1, 0, 0, 2'd0, 0);
    #1;
    chk("x0_pend", sb_if.pending_mask, 32'd0);
    cyc_stall("x0_rd", 0);

    // A latency-3 producer followed by 2 independent instructions: one stall.
    drv(1, 0, 0, 0, 0, 9, 1, 2'd3, 0);  cyc_stall("gap_issue", 0);       // cnt9=3
    drv(1, 1, 1, 2, 1, 20, 1, 2'd0, 0);
    #1;
    chk("gap_pend", sb_if.pending_mask, 32'h0000_0200);
    cyc_stall("gap_ind1", 0);                                            // cnt9=2
    cyc_stall("gap_ind2", 0);                                            // cnt9=1
    drv(1, 0, 0, 9, 1, 21, 0, 2'd0, 0);
    cyc_stall("gap_st", 1);                                              // cnt9=0
    cyc_stall("gap_go", 0);

    // The flush cancels the youngest entry (r12). The older r13 keeps counting.
    drv(1, 0, 0, 0, 0, 13, 1, 2'd3, 0); cyc_stall("fl_old", 0);          // cnt13=3
    drv(1, 0, 0, 0, 0, 12, 1, 2'd2, 0); cyc_stall("fl_young", 0);        // 13=2,12=2
    drv(1, 12, 1, 0, 0, 14, 1, 2'd0, 1);
    #1;
    chk("fl_pend_pre", sb_if.pending_mask, 32'h0000_3000);
    cyc_stall("fl_dom", 0);                                              // 13=1,12=0
    idle();
    #1;
    chk("fl_pend_post", sb_if.pending_mask, 32'h0000_2000);
    drv(1, 12, 1, 0, 0, 0, 0, 2'd0, 0); cyc_stall("fl_rd12", 0);         // 13=0
    idle();
    #1;
    chk("fl_pend_end", sb_if.pending_mask, 32'd0);

    // WAW with a self-read: the new rd3 waits for the old rd3 to drain.
    drv(1, 0, 0, 0, 0, 3, 1, 2'd3, 0);  cyc_stall("waw_p1", 0);          // cnt3=3
    drv(1, 3, 1, 0, 0, 3, 1, 2'd0, 0);
    cyc_stall("waw_st1", 1);
    cyc_stall("waw_st2", 1);
    cyc_stall("waw_st3", 1);
    cyc_stall("waw_go", 0);                                              // cnt3=0
    idle();
    #1;
    chk("waw_pend", sb_if.pending_mask, 32'd0);

    // The newer latency overwrites the older one (3 -> 1): one stall only.
    drv(1, 0, 0, 0, 0, 3, 1, 2'd3, 0);  cyc_stall("ow_p1", 0);           // cnt3=3
    drv(1, 0, 0, 0, 0, 3, 1, 2'd1, 0);  cyc_stall("ow_p2", 0);           // cnt3=1
    drv(1, 0, 0, 3, 1, 4, 0, 2'd0, 0);
    cyc_stall("ow_st", 1);
    cyc_stall("ow_go", 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
